// File: rtl/t5_hart_sched.sv
// Barrel-hart scheduler for the 4-hart t5 core: Johnson slot counter, per-hart run state, fetch-stall timeout.
// Optional issued-slot counter output perf_o when T5_HART_SCHED_PERF_EN is defined.
module t5_hart_sched #(
    parameter int TOW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  run_i,
    input  logic [3:0]  irq_i,
    input  logic        wfi_i,
    input  logic [1:0]  wfi_id_i,
    input  logic        iack_i,
    output logic        ena_o,
    output logic [1:0]  hart_o,
    output logic [1:0]  hidx_o,
    output logic        valid_o,
    output logic [7:0]  hstat_o,
    output logic        tout_o
`ifdef T5_HART_SCHED_PERF_EN
    ,
    output logic [31:0] perf_o
`endif
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_RUN   = 2'b01,
        ST_SLEEP = 2'b10,
        ST_ILL   = 2'b11
    } hst_e;

    hst_e [3:0]     st_q, st_d;
    logic [1:0]     hart_q, hart_d;
    logic [TOW-1:0] stall_q, stall_d;
`ifdef T5_HART_SCHED_PERF_EN
    logic [31:0]    perf_q, perf_d;
`endif

    assign ena_o   = iack_i & ~rst;
    assign hart_d  = ena_o ? {hart_q[0], ~hart_q[1]} : hart_q;
    // Johnson 00,01,11,10 -> binary 0,1,2,3
    assign hidx_o  = {hart_q[1], hart_q[1] ^ hart_q[0]};
    assign hart_o  = hart_q;
    assign valid_o = (st_q[hidx_o] == ST_RUN);
    assign hstat_o = st_q;
    assign tout_o  = &stall_q;
    assign stall_d = iack_i ? '0 : ((&stall_q) ? stall_q : stall_q + 1'b1);
`ifdef T5_HART_SCHED_PERF_EN
    assign perf_d  = (ena_o && valid_o) ? perf_q + 32'd1 : perf_q;
    assign perf_o  = perf_q;
`endif

    // irq beats a same-cycle wfi; a wfi aimed at a non-RUN hart falls through to hold
    always_comb begin
        st_d = st_q;
        for (int n = 0; n < 4; n++) begin
            if (!run_i[n] || st_q[n] == ST_ILL) begin
                st_d[n] = ST_OFF;
            end else begin
                case (st_q[n])
                    ST_OFF:   st_d[n] = ST_RUN;
                    ST_RUN:   if (wfi_i && wfi_id_i == 2'(n) && !irq_i[n]) st_d[n] = ST_SLEEP;
                    ST_SLEEP: if (irq_i[n]) st_d[n] = ST_RUN;
                    default:  st_d[n] = ST_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= {4{ST_OFF}};
            hart_q  <= 2'b00;
            stall_q <= '0;
`ifdef T5_HART_SCHED_PERF_EN
            perf_q  <= 32'd0;
`endif
        end else begin
            st_q    <= st_d;
            hart_q  <= hart_d;
            stall_q <= stall_d;
`ifdef T5_HART_SCHED_PERF_EN
            perf_q  <= perf_d;
`endif
        end
    end

endmodule

// File: tb/tb_t5_hart_sched.sv
// Directed bench for t5_hart_sched (TOW=4): vector table plus stall-timeout and mid-run reset sequences.
module tb_t5_hart_sched;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wfi, iack;
    logic [3:0] run, irq;
    logic [1:0] wid;
    logic       ena, valid, tout;
    logic [1:0] hart, hidx;
    logic [7:0] hstat;
`ifdef T5_HART_SCHED_PERF_EN
    logic [31:0] perf;
`endif

    t5_hart_sched #(.TOW(4)) dut (
        .clk(clk), .rst(rst), .run_i(run), .irq_i(irq), .wfi_i(wfi),
        .wfi_id_i(wid), .iack_i(iack), .ena_o(ena), .hart_o(hart),
        .hidx_o(hidx), .valid_o(valid), .hstat_o(hstat), .tout_o(tout)
`ifdef T5_HART_SCHED_PERF_EN
        , .perf_o(perf)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] run;
        logic [3:0] irq;
        logic       wfi;
        logic [1:0] wid;
        logic       iack;
        logic       e_ena;   // before the edge
        logic [1:0] e_hart;  // after the edge
        logic       e_valid;
        logic [7:0] e_hstat;
        logic       e_tout;
    } vec_t;

    vec_t vt[28];
    int   nrun = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nrun++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] j2b(input logic [1:0] h);
        case (h)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic drive(input logic r, input logic [3:0] ru, input logic [3:0] ir,
                         input logic w, input logic [1:0] wi, input logic ia);
        rst = r; run = ru; irq = ir; wfi = w; wid = wi; iack = ia;
    endtask

    task automatic post(input string p, input logic [1:0] h, input logic v,
                        input logic [7:0] s, input logic t);
        chk({p, "_hart"}, 32'(hart), 32'(h));
        chk({p, "_hidx"}, 32'(hidx), 32'(j2b(h)));
        chk({p, "_valid"}, 32'(valid), 32'(v));
        chk({p, "_hstat"}, 32'(hstat), 32'(s));
        chk({p, "_tout"}, 32'(tout), 32'(t));
    endtask

    initial begin
        //            rst run    irq    wfi wid  iack ena hart   vld hstat  tout
        vt[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0};
        vt[4]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
        vt[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
        vt[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0};
        vt[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        // harts 0 and 2 come up
        vt[10] = '{1'b0, 4'h5, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h11, 1'b0};
        vt[11] = '{1'b0, 4'h5, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b11, 1'b1, 8'h11, 1'b0};
        vt[12] = '{1'b0, 4'h5, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h11, 1'b0};
        vt[13] = '{1'b0, 4'h5, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h11, 1'b0};
        // hart 1 up, then WFI sleeps it, irq wakes it
        vt[14] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h15, 1'b0};
        vt[15] = '{1'b0, 4'h7, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, 2'b11, 1'b1, 8'h19, 1'b0};
        vt[16] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h19, 1'b0};
        vt[17] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h19, 1'b0};
        vt[18] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h19, 1'b0};
        vt[19] = '{1'b0, 4'h7, 4'h2, 1'b0, 2'd0, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 1'b0};
        vt[20] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h15, 1'b0};
        vt[21] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h15, 1'b0};
        vt[22] = '{1'b0, 4'h7, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h15, 1'b0};
        // irq beats same-cycle wfi; then hart 2 sleeps; wfi to OFF hart 3 ignored; run[2] drop
        vt[23] = '{1'b0, 4'h7, 4'h4, 1'b1, 2'd2, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 1'b0};
        vt[24] = '{1'b0, 4'h7, 4'h0, 1'b1, 2'd2, 1'b1, 1'b1, 2'b10, 1'b0, 8'h25, 1'b0};
        vt[25] = '{1'b0, 4'h7, 4'h0, 1'b1, 2'd3, 1'b1, 1'b1, 2'b00, 1'b1, 8'h25, 1'b0};
        vt[26] = '{1'b0, 4'h3, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h05, 1'b0};
        vt[27] = '{1'b0, 4'h3, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b11, 1'b0, 8'h05, 1'b0};

        drive(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1);
        #1;
        for (int i = 0; i < 28; i++) begin
            drive(vt[i].rst, vt[i].run, vt[i].irq, vt[i].wfi, vt[i].wid, vt[i].iack);
            #1;
            chk($sformatf("v%0d_ena", i), 32'(ena), 32'(vt[i].e_ena));
            @(posedge clk); #1;
            post($sformatf("v%0d", i), vt[i].e_hart, vt[i].e_valid, vt[i].e_hstat, vt[i].e_tout);
        end

        // fetch stall: slot frozen, tout after 15 un-acked edges and holds
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 4'h3, 4'h0, 1'b0, 2'd0, 1'b0);
            #1;
            chk($sformatf("st%0d_ena", k), 32'(ena), 32'd0);
            @(posedge clk); #1;
            post($sformatf("st%0d", k), 2'b11, 1'b0, 8'h05, (k >= 15));
        end
        drive(1'b0, 4'h3, 4'h0, 1'b0, 2'd0, 1'b1);
        #1;
        chk("ack_ena", 32'(ena), 32'd1);
        @(posedge clk); #1;
        post("ack", 2'b10, 1'b0, 8'h05, 1'b0);

        // clean restart, all harts up, 12 issued slots
        drive(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1);
        @(posedge clk); #1;
        post("rs0", 2'b00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1);
        @(posedge clk); #1;
        post("up", 2'b01, 1'b1, 8'h55, 1'b0);
`ifdef T5_HART_SCHED_PERF_EN
        chk("perf_up", perf, 32'd0);
`endif
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("full%0d_valid", k), 32'(valid), 32'd1);
        end
        chk("full_hart", 32'(hart), 32'(2'b01));
`ifdef T5_HART_SCHED_PERF_EN
        chk("perf12", perf, 32'd12);
`endif
        // mid-run reset with iack still high
        drive(1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1);
        #1;
        chk("rst_ena", 32'(ena), 32'd0);
        @(posedge clk); #1;
        post("rs1", 2'b00, 1'b0, 8'h00, 1'b0);
        chk("rs1_ena", 32'(ena), 32'd0);
`ifdef T5_HART_SCHED_PERF_EN
        chk("perf_rst", perf, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
